md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Sequencer and owner of the HI/LO multiply/divide resource in stage E of the 5-stage pipeline.
//  Takes the decoder's 4-bit md_op code plus rs/rt operands.
//  Runs mult/multu/div/divu as multi-cycle jobs and services mthi/mtlo/mfhi/mflo.
//  Raises a D-stage stall request while the unit is occupied.
// PARAMETERS
//  MULT_CYC  5   cycles from accepted mult/multu to HI/LO update
//  DIV_CYC   10  cycles from accepted div/divu to HI/LO update
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-low reset
//  md_op     in   4   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//  cancel    in   1   E-stage instruction flushed (exception/interrupt); suppresses md_op this cycle
//  rs_val    in   32  forwarded rs operand
//  rt_val    in   32  forwarded rt operand
//  d_md      in   1   D-stage instruction has md_op 1..8
//  busy      out  1   job in progress
//  stall_d   out  1   stall request to D stage
//  md_rdata  out  32  HI when md_op=5, LO when md_op=6, else 0 (combinational)
//  hi        out  32  architectural HI
//  lo        out  32  architectural LO
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, cnt=0, hi=lo=0, busy=0, shadow results=0.
//  Reset mid-job aborts the job; HI/LO read 0 afterwards.
//  FSM states: IDLE, RUN.
//  - IDLE, md_op in 1..4, !cancel: compute 64-bit result into shadow_hi/shadow_lo.
//    Load cnt = MULT_CYC or DIV_CYC; go RUN next edge.
//  - RUN: cnt decrements each edge. At the edge where cnt reaches 1, write hi/lo from shadow.
//    Go IDLE on that same edge.
//  - Net latency: issue at edge 0 -> hi/lo visible after edge MULT_CYC (DIV_CYC).
//    busy is high for exactly MULT_CYC (DIV_CYC) cycles.
//  - cancel high in RUN does NOT abort: an accepted job always completes.
//  - Legal sources:
//    - md_op in 1..8 while busy is a protocol violation.
//    - stall_d guarantees it cannot occur.
//    - It is ignored (no state change).
//  mthi/mtlo: in IDLE with !cancel, write hi/lo <= rs_val on the next edge. Single cycle; busy stays 0.
//  mfhi/mflo: md_rdata combinational from current hi/lo; no state change.
//  Arithmetic:
//  - mult: signed 32x32->64; hi=upper 32 bits, lo=lower 32 bits.
//  - multu: unsigned 32x32->64; hi=upper 32 bits, lo=lower 32 bits.
//  - div: signed; lo=quotient truncated toward zero; hi=remainder with sign of dividend.
//  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - divu: unsigned quotient/remainder.
//  - Divisor 0 (div/divu): job runs full DIV_CYC; hi/lo left unchanged at completion.
//  stall_d = d_md & (busy | (md_op in 1..4 & !cancel)). Covers the issue cycle and all RUN cycles.
//  Simultaneous events:
//  - Completion edge with d_md=1: stall_d drops in the cycle after completion (busy=0).
//  - mfhi issued then reads the new value.
// TESTING
//  1 mult rs=0xFFFFFFFB rt=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2 divu 7/2 -> busy 10 cycles; then lo=3, hi=1.
//    div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3 mult issued, d_md=1 held -> stall_d=1 from issue cycle through 5 busy cycles.
//    stall_d=0 the cycle after; mfhi returns product.
//  4 mthi rs=0x1234 then mfhi -> md_rdata=0x1234; busy never asserted.
//    mtlo with cancel=1 -> lo unchanged.
//  5 div with cancel=1 -> no busy, hi/lo unchanged.
//    div accepted then cancel=1 mid-run -> completes normally.
//    divu by 0 -> hi/lo unchanged.
//  6 reset low at cycle 3 of a div -> busy=0, hi=lo=0 immediately (async).
//    New mult after release works normally.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide unit for the E stage: sequences multi-cycle mult/div jobs,
// services mthi/mtlo/mfhi/mflo and requests a D-stage stall while occupied.
module md_unit_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
  logic               div0_q, div0_d;
  logic               job_op;

  // Full 64-bit product; truncating a 64-bit signed multiply is exact modulo 2^64.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] sa, sb, p;
    sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return p;
  endfunction

  // Returns {remainder, quotient}; magnitude division keeps 0x80000000 / -1 well defined.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic        neg_a, neg_b;
    logic [31:0] ma, mb, q, r, qo, ro;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (32'd0 - a) : a;
    mb    = neg_b ? (32'd0 - b) : b;
    if (mb == 32'd0) mb = 32'd1;
    q     = ma / mb;
    r     = ma % mb;
    qo    = (neg_a ^ neg_b) ? (32'd0 - q) : q;
    ro    = neg_a ? (32'd0 - r) : r;
    return {ro, qo};
  endfunction

  assign job_op = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    div0_d      = div0_q;
    case (state_q)
      IDLE: begin
        if (!cancel) begin
          if (job_op) begin
            state_d = RUN;
            if (md_op == OP_MULT || md_op == OP_MULTU) begin
              {shadow_hi_d, shadow_lo_d} = mul_fn(rs_val, rt_val, md_op == OP_MULT);
              cnt_d  = CNT_W'(MULT_CYC);
              div0_d = 1'b0;
            end else begin
              {shadow_hi_d, shadow_lo_d} = div_fn(rs_val, rt_val, md_op == OP_DIV);
              cnt_d  = CNT_W'(DIV_CYC);
              div0_d = (rt_val == 32'd0);
            end
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      RUN: begin
        // Ops arriving while busy are protocol violations and are dropped here.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!div0_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      div0_q      <= div0_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign stall_d  = d_md & (busy | (job_op & ~cancel));
  assign md_rdata = (md_op == OP_MFHI) ? hi_q :
                    (md_op == OP_MFLO) ? lo_q : 32'd0;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: job latency, arithmetic, stall, moves, cancel and reset.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        cancel;
  logic [31:0] rs_val, rt_val;
  logic        d_md;
  logic        busy, stall_d;
  logic [31:0] md_rdata, hi, lo;

  int tests  = 0;
  int failed = 0;

  md_unit_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .cancel(cancel),
    .rs_val(rs_val), .rt_val(rt_val), .d_md(d_md),
    .busy(busy), .stall_d(stall_d), .md_rdata(md_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a job, hold it busy for cyc cycles; optionally raise cancel or inject mthi mid-run.
  task automatic run_job(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc, input bit cancel_mid,
                         input bit inj_mthi);
    md_op = op; rs_val = a; rt_val = b; cancel = 1'b0;
    step();
    md_op = 4'd0;
    cancel = cancel_mid;
    for (int i = 0; i < cyc; i++) begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      if (inj_mthi && i == 2) begin
        md_op = 4'd7; rs_val = 32'hDEAD_BEEF;
      end else begin
        md_op = 4'd0;
      end
      step();
    end
    md_op = 4'd0;
    cancel = 1'b0;
    check({tag, "_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; md_op = 4'd0; cancel = 1'b0; rs_val = '0; rt_val = '0; d_md = 1'b0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'b0, stall_d}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // mult -5 * 3 with D-stage md instruction waiting
    d_md = 1'b1; md_op = 4'd1; rs_val = 32'hFFFF_FFFB; rt_val = 32'd3;
    #1;
    check("m_stall_issue", {31'b0, stall_d}, 32'd1);
    check("m_busy_issue", {31'b0, busy}, 32'd0);
    step();
    md_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("m_busy_run", {31'b0, busy}, 32'd1);
      check("m_stall_run", {31'b0, stall_d}, 32'd1);
      check("m_hi_pending", hi, 32'd0);
      step();
    end
    check("m_busy_after", {31'b0, busy}, 32'd0);
    check("m_hi", hi, 32'hFFFF_FFFF);
    check("m_lo", lo, 32'hFFFF_FFF1);
    md_op = 4'd5;
    #1;
    check("m_stall_after", {31'b0, stall_d}, 32'd0);
    check("m_mfhi", md_rdata, 32'hFFFF_FFFF);
    md_op = 4'd0; d_md = 1'b0;
    step();

    // divides
    run_job("divu7_2", 4'd4, 32'd7, 32'd2, 10, 1'b0, 1'b0);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    run_job("divneg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_job("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // moves
    md_op = 4'd7; rs_val = 32'h0000_1234;
    step();
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    md_op = 4'd5;
    #1;
    check("mfhi_rd", md_rdata, 32'h0000_1234);
    md_op = 4'd8; rs_val = 32'h5555_5555; cancel = 1'b1;
    step();
    cancel = 1'b0; md_op = 4'd6;
    #1;
    check("mtlo_cancel", lo, 32'h8000_0000);
    check("mflo_rd", md_rdata, 32'h8000_0000);
    md_op = 4'd0;
    #1;
    check("rd_none", md_rdata, 32'd0);

    // cancelled issue
    d_md = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7; cancel = 1'b1;
    #1;
    check("cdiv_stall", {31'b0, stall_d}, 32'd0);
    step();
    md_op = 4'd0; cancel = 1'b0; d_md = 1'b0;
    check("cdiv_busy", {31'b0, busy}, 32'd0);
    check("cdiv_hi", hi, 32'h0000_1234);
    check("cdiv_lo", lo, 32'h8000_0000);

    // cancel mid-run does not abort
    run_job("div100_7", 4'd3, 32'd100, 32'd7, 10, 1'b1, 1'b0);
    check("d100_lo", lo, 32'd14);
    check("d100_hi", hi, 32'd2);

    // divide by zero leaves HI/LO; mthi during run ignored
    run_job("divu0", 4'd4, 32'd5, 32'd0, 10, 1'b0, 1'b1);
    check("dz_lo", lo, 32'd14);
    check("dz_hi", hi, 32'd2);

    // async reset in the middle of a divide
    md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    step();
    md_op = 4'd0;
    step(); step();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    step();

    run_job("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 1'b0);
    check("mu_hi", hi, 32'hFFFF_FFFE);
    check("mu_lo", lo, 32'h0000_0001);
    run_job("mult2", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b0, 1'b0);
    check("m2_hi", hi, 32'd1);
    check("m2_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
